// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with timeout and
// bounded retries, qualifies lock stability, then releases the downstream reset.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       user_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  logic             sync1_q, sync2_q;
  logic             locked_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [3:0]       retry_inc;
  logic             pll_rst_q, user_rst_q, ready_q, fault_q;

  assign locked_s  = sync2_q;
  assign retry_inc = retry_q + 4'd1;

  // relock_req is a one-cycle pulse acted on in the cycle it is high; there is no
  // acknowledge, and it is dropped silently while the PLL is already in reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (relock_req) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end else if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (relock_req) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end else if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (relock_req || !locked_s) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        if (relock_req) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
        retry_d = '0;
      end
    endcase
  end

  // Output flops decode the next state so they switch on the same edge as state_q.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= S_RESET_PLL;
      cnt_q      <= '0;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      user_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sync1_q    <= locked;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      user_rst_q <= (state_d != S_RUN);
      ready_q    <= (state_d == S_RUN);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign user_rst  = user_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
